// File: rtl/pifo_pkg.sv
// Shared definitions for the calendar PIFO: element layout, field positions and helpers.
package pifo_pkg;

  localparam int unsigned VALID_BIT = 31;
  localparam int unsigned OVF_BIT   = 30;
  localparam int unsigned RANK_MSB  = 29;
  localparam int unsigned RANK_LSB  = 12;
  localparam int unsigned ADDR_MSB  = 11;
  localparam int unsigned ADDR_LSB  = 0;

  localparam int unsigned ELEM_W = VALID_BIT + 1;
  localparam int unsigned RANK_W = RANK_MSB - RANK_LSB + 1;
  localparam int unsigned ADDR_W = ADDR_MSB - ADDR_LSB + 1;

  typedef struct packed {
    logic              valid;
    logic              ovf;
    logic [RANK_W-1:0] rank;
    logic [ADDR_W-1:0] addr;
  } pifo_elem_t;

  function automatic pifo_elem_t make_element(
    input logic              valid,
    input logic              ovf,
    input logic [RANK_W-1:0] rank,
    input logic [ADDR_W-1:0] addr
  );
    pifo_elem_t e;
    e.valid = valid;
    e.ovf   = ovf;
    e.rank  = rank;
    e.addr  = addr;
    return e;
  endfunction

  function automatic logic [RANK_W-1:0] get_rank(input logic [ELEM_W-1:0] e);
    return e[RANK_MSB:RANK_LSB];
  endfunction

endpackage

// File: rtl/pifo_deq_reg.sv
// Registered dequeue output with valid/ready hold; loads a new element whenever the array pops.
module pifo_deq_reg
  import pifo_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  pifo_elem_t load_elem,
  input  logic       m_ready,
  output logic       m_valid,
  output pifo_elem_t m_elem,
  output logic       can_load_c
);

  pifo_elem_t out_q, out_d;
  logic       out_valid_q, out_valid_d;

  // A pop overrides the consume; element stays put while valid and not ready.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_d       = load_elem;
      out_valid_d = 1'b1;
    end else if (out_valid_q && m_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_valid    = out_valid_q;
  assign m_elem     = out_q;
  assign can_load_c = !out_valid_q || m_ready;

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// Front-end controller for the calendar PIFO atom array: stages enqueues with their wrap bit,
// drives shared insert/pop controls and pulls the head element into the dequeue port.
module pifo_calendar_ctrl
  import pifo_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned RANK_WIDTH    = 18,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned CNT_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_enq_valid,
  output logic                     s_enq_ready,
  input  logic [RANK_WIDTH-1:0]    s_enq_rank,
  input  logic [ADDR_WIDTH-1:0]    s_enq_addr,
  output logic                     m_deq_valid,
  input  logic                     m_deq_ready,
  output logic [ELEMENT_WIDTH-1:0] m_deq_element,
  output logic [ELEMENT_WIDTH-1:0] out_pifo_input,
  output logic                     out_ctl_insert,
  output logic                     out_ctl_pop,
  output logic                     out_global_overflow_bit,
  input  logic [ELEMENT_WIDTH-1:0] in_pifo_head,
  output logic [CNT_WIDTH-1:0]     out_count
);

  pifo_elem_t            stage_q, stage_d;
  logic                  stage_valid_q, stage_valid_d;
  logic [CNT_WIDTH-1:0]  arr_count_q, arr_count_d;
  logic                  global_ovf_q, global_ovf_d;
  logic [RANK_WIDTH-1:0] last_rank_q, last_rank_d;

  logic [CNT_WIDTH-1:0]  occupancy_c;
  logic [ELEM_W-1:0]     head_c;
  logic                  enq_accept_c;
  logic                  enq_ovf_c;
  logic                  pop_c;
  logic                  deq_can_load_c;
  pifo_elem_t            deq_elem;

  assign head_c       = ELEM_W'(in_pifo_head);
  assign occupancy_c  = arr_count_q + CNT_WIDTH'(stage_valid_q);
  assign s_enq_ready  = occupancy_c < CNT_WIDTH'(DEPTH);
  assign enq_accept_c = s_enq_valid && s_enq_ready;
  // A rank below the last dequeued one has wrapped into the next calendar epoch.
  assign enq_ovf_c    = (s_enq_rank < last_rank_q) ? ~global_ovf_q : global_ovf_q;
  assign pop_c        = (arr_count_q != '0) && deq_can_load_c;

  always_comb begin
    stage_d       = '0;
    stage_valid_d = 1'b0;
    arr_count_d   = arr_count_q;
    global_ovf_d  = global_ovf_q;
    last_rank_d   = last_rank_q;

    if (enq_accept_c) begin
      stage_valid_d = 1'b1;
      stage_d       = make_element(1'b1, enq_ovf_c, RANK_W'(s_enq_rank), ADDR_W'(s_enq_addr));
    end

    if (pop_c) begin
      global_ovf_d = head_c[OVF_BIT];
      last_rank_d  = RANK_WIDTH'(get_rank(head_c));
    end

    // Staged element always inserts; simultaneous insert and pop cancel out.
    case ({stage_valid_q, pop_c})
      2'b10:   arr_count_d = arr_count_q + CNT_WIDTH'(1);
      2'b01:   arr_count_d = arr_count_q - CNT_WIDTH'(1);
      default: arr_count_d = arr_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      arr_count_q   <= '0;
      global_ovf_q  <= 1'b0;
      last_rank_q   <= '0;
    end else begin
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      arr_count_q   <= arr_count_d;
      global_ovf_q  <= global_ovf_d;
      last_rank_q   <= last_rank_d;
    end
  end

  pifo_deq_reg u_deq_reg (
    .clk        (clk),
    .rstn       (rstn),
    .load       (pop_c),
    .load_elem  (pifo_elem_t'(head_c)),
    .m_ready    (m_deq_ready),
    .m_valid    (m_deq_valid),
    .m_elem     (deq_elem),
    .can_load_c (deq_can_load_c)
  );

  assign m_deq_element           = ELEMENT_WIDTH'(deq_elem);
  assign out_pifo_input          = ELEMENT_WIDTH'(stage_q);
  assign out_ctl_insert          = stage_valid_q;
  assign out_ctl_pop             = pop_c;
  assign out_global_overflow_bit = global_ovf_q;
  assign out_count               = occupancy_c;

  // A non-empty array must present a valid head element.
  a_head_valid: assert property (@(posedge clk) disable iff (!rstn)
    (arr_count_q != '0) |-> in_pifo_head[VALID_BIT]);

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Bench for pifo_calendar_ctrl: sorted-queue model of the atom array plus a transaction-level
// reference of the controller, exercised with directed scenarios and random traffic.
module tb_pifo_calendar_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned EW    = 32;
  localparam int unsigned RW    = 18;
  localparam int unsigned AW    = 12;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_enq_valid = 1'b0;
  logic          s_enq_ready;
  logic [RW-1:0] s_enq_rank = '0;
  logic [AW-1:0] s_enq_addr = '0;
  logic          m_deq_valid;
  logic          m_deq_ready = 1'b0;
  logic [EW-1:0] m_deq_element;
  logic [EW-1:0] out_pifo_input;
  logic          out_ctl_insert;
  logic          out_ctl_pop;
  logic          out_global_overflow_bit;
  logic [EW-1:0] in_pifo_head = '0;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  pifo_calendar_ctrl #(
    .DEPTH(DEPTH), .ELEMENT_WIDTH(EW), .RANK_WIDTH(RW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .s_enq_valid             (s_enq_valid),
    .s_enq_ready             (s_enq_ready),
    .s_enq_rank              (s_enq_rank),
    .s_enq_addr              (s_enq_addr),
    .m_deq_valid             (m_deq_valid),
    .m_deq_ready             (m_deq_ready),
    .m_deq_element           (m_deq_element),
    .out_pifo_input          (out_pifo_input),
    .out_ctl_insert          (out_ctl_insert),
    .out_ctl_pop             (out_ctl_pop),
    .out_global_overflow_bit (out_global_overflow_bit),
    .in_pifo_head            (in_pifo_head),
    .out_count               (out_count)
  );

  // Reference state: array contents in service order, staged element, output slot, calendar epoch.
  logic [31:0] arr[$];
  bit          st_v;
  logic [31:0] st_e;
  bit          out_v;
  logic [31:0] out_e;
  bit          g;
  logic [17:0] lr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        o_rdy, o_ins, o_pop, o_dv, o_gov;
  logic [31:0] o_pin, o_de;
  logic [4:0]  o_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Service key: current-epoch elements first, then by rank.
  function automatic logic [18:0] key(input logic [31:0] e, input bit gb);
    return {e[30] ^ gb, e[29:12]};
  endfunction

  function automatic logic [31:0] elem(input bit ovf, input int unsigned rank, input int unsigned addr);
    logic [31:0] e;
    e = {1'b1, ovf, 18'(rank), 12'(addr)};
    return e;
  endfunction

  task automatic model_clear();
    arr.delete();
    st_v = 0; st_e = '0; out_v = 0; out_e = '0; g = 0; lr = '0;
  endtask

  // One clock cycle: drive, compare against the reference, then advance the reference at the edge.
  task automatic step(input bit ev, input logic [17:0] rk, input logic [11:0] ad,
                      input bit dr, input bit rst);
    int unsigned cnt;
    bit          e_rdy, e_pop, acc, g0;
    logic [17:0] lr0;
    logic [31:0] h;
    int          idx;
    s_enq_valid  = ev;
    s_enq_rank   = rk;
    s_enq_addr   = ad;
    m_deq_ready  = dr;
    rstn         = !rst;
    in_pifo_head = (arr.size() != 0) ? arr[0] : 32'h0;
    #2;
    cnt   = arr.size() + int'(st_v);
    e_rdy = cnt < DEPTH;
    e_pop = (arr.size() != 0) && (!out_v || dr);
    o_rdy = s_enq_ready;  o_ins = out_ctl_insert; o_pop = out_ctl_pop;
    o_dv  = m_deq_valid;  o_gov = out_global_overflow_bit;
    o_pin = out_pifo_input; o_de = m_deq_element; o_cnt = out_count;
    check_eq("s_enq_ready",   32'(o_rdy), 32'(e_rdy));
    check_eq("ctl_insert",    32'(o_ins), 32'(st_v));
    check_eq("pifo_input",    o_pin, st_v ? st_e : 32'h0);
    check_eq("ctl_pop",       32'(o_pop), 32'(e_pop));
    check_eq("deq_valid",     32'(o_dv), 32'(out_v));
    check_eq("deq_element",   o_de, out_e);
    check_eq("global_ovf",    32'(o_gov), 32'(g));
    check_eq("count",         32'(o_cnt), 32'(cnt));
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      g0  = g;
      lr0 = lr;
      acc = ev && e_rdy;
      if (e_pop) begin
        h = arr.pop_front();
        out_v = 1; out_e = h; g = h[30]; lr = h[29:12];
      end else if (out_v && dr) begin
        out_v = 0;
      end
      if (st_v) begin
        idx = arr.size();
        for (int i = 0; i < arr.size(); i++) begin
          if (key(arr[i], g0) > key(st_e, g0)) begin
            idx = i;
            break;
          end
        end
        arr.insert(idx, st_e);
      end
      if (acc) begin
        st_v = 1;
        st_e = {1'b1, (rk < lr0) ? ~g0 : g0, rk, ad};
      end else begin
        st_v = 0;
        st_e = '0;
      end
    end
    #1;
  endtask

  task automatic idle(input bit dr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, dr, 1'b0);
  endtask

  logic [17:0] cur_rank;
  logic [17:0] rr;

  initial begin
    model_clear();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b0, '0, '0, 1'b1, 1'b1);
    check_eq("rst_ready", 32'(o_rdy), 32'd1);
    check_eq("rst_count", 32'(o_cnt), 32'd0);

    // Single enqueue: insert at T+1, pop at T+2, dequeue at T+3
    step(1'b1, 18'd10, 12'h005, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("t1_pin", o_pin, 32'h8000A005);
    check_eq("t1_ins", 32'(o_ins), 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("t1_pop", 32'(o_pop), 32'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("t1_dv",  32'(o_dv), 32'd1);
    check_eq("t1_de",  o_de, 32'h8000A005);
    check_eq("t1_gov", 32'(o_gov), 32'd0);

    // Rank ordering: a filler element occupies the output while 30,10,20 are stored
    step(1'b1, 18'd12, 12'd0, 1'b0, 1'b0);
    step(1'b1, 18'd30, 12'd1, 1'b0, 1'b0);
    step(1'b1, 18'd10, 12'd2, 1'b0, 1'b0);
    step(1'b1, 18'd20, 12'd3, 1'b0, 1'b0);
    idle(1'b0, 4);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("ord_0", 32'(o_de[11:0]), 32'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("ord_1_dv", 32'(o_dv), 32'd1);
    check_eq("ord_1", 32'(o_de[11:0]), 32'd2);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("ord_2", 32'(o_de[11:0]), 32'd3);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("ord_3", 32'(o_de[11:0]), 32'd1);
    idle(1'b1, 2);

    // Calendar wrap
    step(1'b1, 18'h3FFF0, 12'd7, 1'b1, 1'b0);
    idle(1'b1, 3);
    check_eq("wrap_pre_de", o_de, elem(1'b0, 32'h3FFF0, 7));
    step(1'b1, 18'h00005, 12'd8, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("wrap_stage_ovf", 32'(o_pin[30]), 32'd1);
    idle(1'b1, 2);
    check_eq("wrap_dv",   32'(o_dv), 32'd1);
    check_eq("wrap_de",   o_de, 32'hC0005008);
    check_eq("wrap_gov",  32'(o_gov), 32'd1);
    check_eq("wrap_rank", 32'(o_de[29:12]), 32'd5);
    idle(1'b1, 2);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 20; i++) step(1'b1, 18'(100 + i), 12'(i), 1'b0, 1'b0);
    idle(1'b0, 3);
    check_eq("full_ready", 32'(o_rdy), 32'd0);
    check_eq("full_count", 32'(o_cnt), 32'd16);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("refill_ready", 32'(o_rdy), 32'd1);
    check_eq("refill_count", 32'(o_cnt), 32'd15);

    // Output holds while not ready
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      check_eq("hold_de",  o_de, elem(1'b1, 101, 1));
      check_eq("hold_pop", 32'(o_pop), 32'd0);
    end

    // Staged insert and pop in the same cycle
    step(1'b1, 18'd200, 12'h0AA, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("both_ins", 32'(o_ins), 32'd1);
    check_eq("both_pop", 32'(o_pop), 32'd1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("both_count", 32'(o_cnt), 32'd15);
    idle(1'b1, 20);

    // Random traffic with rank drift that wraps the calendar
    cur_rank = 18'h3F000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) rr = 18'($urandom);
      else begin
        cur_rank = 18'(cur_rank + 18'($urandom_range(0, 3000)));
        rr = cur_rank;
      end
      step($urandom_range(0, 9) < 6, rr, 12'($urandom), $urandom_range(0, 9) < 7, 1'b0);
    end

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) step(1'b1, 18'(1000 + i), 12'(i), 1'b1, 1'b0);
    step(1'b1, 18'd2000, 12'd0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("mid_rst_ready", 32'(o_rdy), 32'd1);
    check_eq("mid_rst_dv",    32'(o_dv), 32'd0);
    check_eq("mid_rst_ins",   32'(o_ins), 32'd0);
    check_eq("mid_rst_pop",   32'(o_pop), 32'd0);
    check_eq("mid_rst_gov",   32'(o_gov), 32'd0);
    check_eq("mid_rst_de",    o_de, 32'd0);
    check_eq("mid_rst_pin",   o_pin, 32'd0);
    check_eq("mid_rst_cnt",   32'(o_cnt), 32'd0);
    step(1'b1, 18'd7, 12'd9, 1'b1, 1'b0);
    idle(1'b1, 3);
    check_eq("post_rst_dv",  32'(o_dv), 32'd1);
    check_eq("post_rst_de",  o_de, 32'h80007009);
    check_eq("post_rst_gov", 32'(o_gov), 32'd0);
    idle(1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
